// File: rtl/mem_arb_pkg.sv
// Shared definitions for the 2:1 memory arbiter.
// Build option: MEM_ARB_RAW_BYPASS_EN (see mem_arb_2to1.sv).
package mem_arb_pkg;

    // Default geometry of the shared mem_512x8b instance.
    localparam int unsigned AW_DEF = 9;
    localparam int unsigned DW_DEF = 8;

    // Arbitration priority state.
    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } arb_state_e;

    // Owner of the read currently returning from memory.
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_raw_chk.sv
// Read-after-write tracker for the shared memory. The memory commits a write one
// cycle late, so a read of the same address in the following cycle would see
// stale data.
// Build option MEM_ARB_RAW_BYPASS_EN: instead of flagging hits for a stall, the
// last write data is kept and forwarded in place of the stale memory read data.
module mem_arb_raw_chk
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
`ifdef MEM_ARB_RAW_BYPASS_EN
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic          o_fwd_vld,
    output logic [DW-1:0] o_fwd_data
`else
    input  logic [AW-1:0] i_a_addr,
    input  logic [AW-1:0] i_b_addr,
    output logic          o_a_hit,
    output logic          o_b_hit
`endif
);

    logic          wr_vld_q;
    logic [AW-1:0] wr_addr_q;

    // Record the write accepted in the previous cycle.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            wr_vld_q <= i_wr_en;
            if (i_wr_en) begin
                wr_addr_q <= i_wr_addr;
            end
        end
    end

`ifdef MEM_ARB_RAW_BYPASS_EN
    logic [DW-1:0] wr_data_q;
    logic          fwd_vld_q;
    logic [DW-1:0] fwd_data_q;
    logic          rd_hit;

    // A granted read that hits the pending write must take the forwarded data.
    always_comb begin
        rd_hit = i_rd_en && wr_vld_q && (i_rd_addr == wr_addr_q);
    end

    // Hold write data, then latch it for the return cycle of a hitting read.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_data_q  <= '0;
            fwd_vld_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            if (i_wr_en) begin
                wr_data_q <= i_wr_data;
            end
            fwd_vld_q <= rd_hit;
            if (rd_hit) begin
                fwd_data_q <= wr_data_q;
            end
        end
    end

    assign o_fwd_vld  = fwd_vld_q;
    assign o_fwd_data = fwd_data_q;
`else
    // Address match against the pending write, per requester.
    always_comb begin
        o_a_hit = wr_vld_q && (i_a_addr == wr_addr_q);
        o_b_hit = wr_vld_q && (i_b_addr == wr_addr_q);
    end
`endif

endmodule

// File: rtl/mem_arb_2to1.sv
// Two-port arbiter in front of a single mem_512x8b. Port A normally has priority;
// port B gets forced priority after STARVE_LIM consecutive refused cycles.
// Build option MEM_ARB_RAW_BYPASS_EN: forward write data instead of stalling a
// same-address read in the cycle after a write.
module mem_arb_2to1
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW         = AW_DEF,
    parameter int unsigned DW         = DW_DEF,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic          i_clk,
    input  logic          i_nrst,
    input  logic          i_a_req,
    input  logic          i_a_we,
    input  logic [AW-1:0] i_a_addr,
    input  logic [DW-1:0] i_a_wdata,
    output logic          o_a_gnt,
    output logic          o_a_rvalid,
    output logic [DW-1:0] o_a_rdata,
    input  logic          i_b_req,
    input  logic          i_b_we,
    input  logic [AW-1:0] i_b_addr,
    input  logic [DW-1:0] i_b_wdata,
    output logic          o_b_gnt,
    output logic          o_b_rvalid,
    output logic [DW-1:0] o_b_rdata,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_we,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_re,
    input  logic [DW-1:0] i_mem_rdata
);

    localparam logic [3:0] STARVE_LIM_W = 4'(STARVE_LIM);

    arb_state_e    state_q, state_d;
    logic [3:0]    starve_q, starve_d;
    logic          rvalid_q;
    owner_e        owner_q;
    logic          a_stall, b_stall;
    logic          a_ok, b_ok;
    logic          a_gnt, b_gnt;
    logic [DW-1:0] rd_data;

`ifdef MEM_ARB_RAW_BYPASS_EN
    logic          fwd_vld;
    logic [DW-1:0] fwd_data;

    mem_arb_raw_chk #(
        .AW(AW),
        .DW(DW)
    ) u_raw_chk (
        .i_clk      (i_clk),
        .i_nrst     (i_nrst),
        .i_wr_en    (o_mem_we),
        .i_wr_addr  (o_mem_addr),
        .i_wr_data  (o_mem_wdata),
        .i_rd_en    (o_mem_re),
        .i_rd_addr  (o_mem_addr),
        .o_fwd_vld  (fwd_vld),
        .o_fwd_data (fwd_data)
    );

    assign a_stall = 1'b0;
    assign b_stall = 1'b0;
    assign rd_data = fwd_vld ? fwd_data : i_mem_rdata;
`else
    logic a_hit, b_hit;

    mem_arb_raw_chk #(
        .AW(AW),
        .DW(DW)
    ) u_raw_chk (
        .i_clk     (i_clk),
        .i_nrst    (i_nrst),
        .i_wr_en   (o_mem_we),
        .i_wr_addr (o_mem_addr),
        .i_a_addr  (i_a_addr),
        .i_b_addr  (i_b_addr),
        .o_a_hit   (a_hit),
        .o_b_hit   (b_hit)
    );

    // Only reads are held off by a pending same-address write.
    assign a_stall = a_hit & ~i_a_we;
    assign b_stall = b_hit & ~i_b_we;
    assign rd_data = i_mem_rdata;
`endif

    // Grant selection: priority holder wins, the other port takes any idle slot.
    always_comb begin
        a_ok  = i_a_req & ~a_stall;
        b_ok  = i_b_req & ~b_stall;
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        case (state_q)
            PRI_A: begin
                a_gnt = a_ok;
                b_gnt = b_ok & ~a_ok;
            end
            PRI_B: begin
                b_gnt = b_ok;
                a_gnt = a_ok & ~b_ok;
            end
            default: ;
        endcase
        a_gnt = a_gnt & i_nrst;
        b_gnt = b_gnt & i_nrst;
    end

    // Starvation counter and priority state next-state logic.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            PRI_A: begin
                if (i_b_req && !b_gnt) begin
                    starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
                end else begin
                    starve_d = '0;
                end
                if (starve_d >= STARVE_LIM_W) begin
                    state_d = PRI_B;
                end
            end
            PRI_B: begin
                if (b_gnt || !i_b_req) begin
                    state_d  = PRI_A;
                    starve_d = '0;
                end
            end
            default: begin
                state_d  = PRI_A;
                starve_d = '0;
            end
        endcase
    end

    // Arbitration state and read-return tracking registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q  <= PRI_A;
            starve_q <= '0;
            rvalid_q <= 1'b0;
            owner_q  <= OWN_A;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            rvalid_q <= o_mem_re;
            owner_q  <= b_gnt ? OWN_B : OWN_A;
        end
    end

    // Memory interface mux driven by the granted port; idle drives all zeros.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_we    = 1'b0;
        o_mem_re    = 1'b0;
        if (a_gnt) begin
            o_mem_addr  = i_a_addr;
            o_mem_wdata = i_a_wdata;
            o_mem_we    = i_a_we;
            o_mem_re    = ~i_a_we;
        end else if (b_gnt) begin
            o_mem_addr  = i_b_addr;
            o_mem_wdata = i_b_wdata;
            o_mem_we    = i_b_we;
            o_mem_re    = ~i_b_we;
        end
    end

    // Handshake outputs and read data steering to the owning port.
    always_comb begin
        o_a_gnt    = a_gnt;
        o_b_gnt    = b_gnt;
        o_a_rvalid = rvalid_q && (owner_q == OWN_A);
        o_b_rvalid = rvalid_q && (owner_q == OWN_B);
        o_a_rdata  = o_a_rvalid ? rd_data : '0;
        o_b_rdata  = o_b_rvalid ? rd_data : '0;
    end

endmodule

// File: tb/tb_mem_arb_2to1.sv
// Self-checking bench for mem_arb_2to1 with a behavioural mem_512x8b model.
// Expectations follow MEM_ARB_RAW_BYPASS_EN when it is defined.
module tb_mem_arb_2to1;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          o_a_gnt, o_a_rvalid, o_b_gnt, o_b_rvalid;
    logic [DW-1:0] o_a_rdata, o_b_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } exp_t;
    exp_t          sb_q[$];
    logic [DW-1:0] ref_mem [512];

    always #5 clk = ~clk;

    mem_arb_2to1 #(
        .AW(AW),
        .DW(DW),
        .STARVE_LIM(4)
    ) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_a_req     (a_req),
        .i_a_we      (a_we),
        .i_a_addr    (a_addr),
        .i_a_wdata   (a_wdata),
        .o_a_gnt     (o_a_gnt),
        .o_a_rvalid  (o_a_rvalid),
        .o_a_rdata   (o_a_rdata),
        .i_b_req     (b_req),
        .i_b_we      (b_we),
        .i_b_addr    (b_addr),
        .i_b_wdata   (b_wdata),
        .o_b_gnt     (o_b_gnt),
        .o_b_rvalid  (o_b_rvalid),
        .o_b_rdata   (o_b_rdata),
        .o_mem_addr  (mem_addr),
        .o_mem_we    (mem_we),
        .o_mem_wdata (mem_wdata),
        .o_mem_re    (mem_re),
        .i_mem_rdata (mem_rdata)
    );

    // Memory model: registered read, write committed one cycle after acceptance.
    logic [DW-1:0] mem [512];
    logic          mw_q = 1'b0;
    logic [AW-1:0] ma_q = '0;
    logic [DW-1:0] md_q = '0;
    always @(posedge clk) begin
        mw_q <= mem_we;
        ma_q <= mem_addr;
        md_q <= mem_wdata;
        if (mw_q) mem[ma_q] <= md_q;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Check returning reads, record new accesses, then advance one clock.
    task automatic tick();
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq("a_rvalid", o_a_rvalid, e.port == 1'b0);
            check_eq("b_rvalid", o_b_rvalid, e.port == 1'b1);
            if (e.port) begin
                check_eq("b_rdata", o_b_rdata, e.data);
                check_eq("a_rdata_idle", o_a_rdata, 0);
            end else begin
                check_eq("a_rdata", o_a_rdata, e.data);
                check_eq("b_rdata_idle", o_b_rdata, 0);
            end
        end else begin
            check_eq("a_rvalid_idle", o_a_rvalid, 0);
            check_eq("b_rvalid_idle", o_b_rvalid, 0);
            check_eq("a_rdata_zero", o_a_rdata, 0);
            check_eq("b_rdata_zero", o_b_rdata, 0);
        end
        check_eq("gnt_onehot", o_a_gnt & o_b_gnt, 0);
        check_eq("gnt_wo_req", (o_a_gnt & ~a_req) | (o_b_gnt & ~b_req), 0);
        if (o_a_gnt && !a_we) sb_q.push_back('{1'b0, ref_mem[a_addr]});
        if (o_a_gnt && a_we) ref_mem[a_addr] = a_wdata;
        if (o_b_gnt && !b_we) sb_q.push_back('{1'b1, ref_mem[b_addr]});
        if (o_b_gnt && b_we) ref_mem[b_addr] = b_wdata;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Request on one port and hold until granted (bounded).
    task automatic xfer(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] d);
        bit done = 1'b0;
        if (!port) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
        end
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            if ((!port && o_a_gnt) || (port && o_b_gnt)) done = 1'b1;
            tick();
            if (done) begin
                if (!port) a_req = 1'b0;
                else b_req = 1'b0;
            end
        end
        check_eq("xfer_granted", done, 1);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_gnt"}, {o_a_gnt, o_b_gnt}, 0);
        check_eq({tag, "_rvalid"}, {o_a_rvalid, o_b_rvalid}, 0);
        check_eq({tag, "_rdata"}, {o_a_rdata, o_b_rdata}, 0);
        check_eq({tag, "_mem_ctl"}, {mem_we, mem_re}, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        // Reset: requests held high must not be granted.
        @(negedge clk);
        a_req = 1'b1; b_req = 1'b1; a_addr = 9'h010; b_addr = 9'h020;
        #1;
        check_all_zero("reset");
        tick();
        a_req = 1'b0; b_req = 1'b0;
        nrst = 1'b1;
        tick();

        // Known contents for later reads.
        xfer(1'b0, 1'b1, 9'h000, 8'h00);
        tick();

        // Single port: write 0x1FF, read 0x000, read 0x1FF.
        a_req = 1'b1; a_we = 1'b1; a_addr = 9'h1FF; a_wdata = 8'h5A;
        #1;
        check_eq("sp_wr_gnt", o_a_gnt, 1);
        check_eq("sp_mem_we", {mem_we, mem_re}, 2'b10);
        check_eq("sp_mem_addr", mem_addr, 9'h1FF);
        check_eq("sp_mem_wdata", mem_wdata, 8'h5A);
        tick();
        a_we = 1'b0; a_addr = 9'h000;
        #1;
        check_eq("sp_rd0_gnt", o_a_gnt, 1);
        check_eq("sp_mem_re", {mem_we, mem_re}, 2'b01);
        tick();
        a_addr = 9'h1FF;
        #1;
        check_eq("sp_rd1_gnt", o_a_gnt, 1);
        tick();
        a_req = 1'b0;
        #1;
        check_eq("sp_rvalid_5a", {o_a_rvalid, o_a_rdata}, {1'b1, 8'h5A});
        tick();
        tick();

        // RAW: A writes 0x010, B reads 0x010 in the next cycle.
        a_req = 1'b1; a_we = 1'b1; a_addr = 9'h010; a_wdata = 8'h33;
        #1;
        check_eq("raw_wr_gnt", o_a_gnt, 1);
        tick();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'h010;
        #1;
`ifdef MEM_ARB_RAW_BYPASS_EN
        check_eq("raw_byp_gnt_n1", o_b_gnt, 1);
        tick();
        b_req = 1'b0;
        #1;
        check_eq("raw_byp_rvalid_n2", {o_b_rvalid, o_b_rdata}, {1'b1, 8'h33});
`else
        check_eq("raw_stall_gnt_n1", o_b_gnt, 0);
        check_eq("raw_stall_mem_re", mem_re, 0);
        tick();
        #1;
        check_eq("raw_stall_gnt_n2", o_b_gnt, 1);
        tick();
        b_req = 1'b0;
        #1;
        check_eq("raw_stall_rvalid_n3", {o_b_rvalid, o_b_rdata}, {1'b1, 8'h33});
`endif
        tick();
        tick();

        // RAW with the other port free to take the slot.
        xfer(1'b1, 1'b1, 9'h020, 8'h44);
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h020;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'h1FF;
        #1;
`ifdef MEM_ARB_RAW_BYPASS_EN
        check_eq("raw2_gnt", {o_a_gnt, o_b_gnt}, 2'b10);
        tick();
        a_req = 1'b0;
        #1;
        check_eq("raw2_gnt_next", {o_a_gnt, o_b_gnt}, 2'b01);
        tick();
        b_req = 1'b0;
`else
        check_eq("raw2_gnt", {o_a_gnt, o_b_gnt}, 2'b01);
        tick();
        b_req = 1'b0;
        #1;
        check_eq("raw2_gnt_next", {o_a_gnt, o_b_gnt}, 2'b10);
        tick();
        a_req = 1'b0;
`endif
        tick();
        tick();

        // Back-to-back writes to one address: last write wins.
        xfer(1'b0, 1'b1, 9'h030, 8'h77);
        xfer(1'b0, 1'b1, 9'h030, 8'h88);
        xfer(1'b0, 1'b0, 9'h030, 8'h00);
        check_eq("ref_last_wins", ref_mem[9'h030], 8'h88);
        tick();
        tick();

        // Interleaved reads from both ports.
        xfer(1'b0, 1'b1, 9'h004, 8'h11);
        xfer(1'b1, 1'b1, 9'h005, 8'h22);
        tick();
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h004;
        #1;
        check_eq("il_a_gnt", o_a_gnt, 1);
        tick();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'h005;
        #1;
        check_eq("il_b_gnt", o_b_gnt, 1);
        check_eq("il_a_ret", {o_a_rvalid, o_a_rdata, o_b_rvalid}, {1'b1, 8'h11, 1'b0});
        tick();
        b_req = 1'b0;
        #1;
        check_eq("il_b_ret", {o_b_rvalid, o_b_rdata, o_a_rvalid}, {1'b1, 8'h22, 1'b0});
        tick();
        tick();

        // Contention with STARVE_LIM = 4: A,A,A,A,B repeating.
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h004;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'h005;
        for (int i = 0; i < 15; i++) begin
            #1;
            check_eq($sformatf("cont_gnt_%0d", i), {o_a_gnt, o_b_gnt},
                     (i % 5 == 4) ? 2'b01 : 2'b10);
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        tick();
        tick();

        // Reset in the cycle after an A read grant.
        a_req = 1'b1; a_we = 1'b0; a_addr = 9'h004;
        #1;
        check_eq("rst_rd_gnt", o_a_gnt, 1);
        tick();
        nrst = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 9'h005;
        #1;
        check_all_zero("mid_reset");
        sb_q.delete();
        tick();
        tick();
        nrst = 1'b1;
        #1;
        check_eq("post_rst_gnt", {o_a_gnt, o_b_gnt}, 2'b10);
        check_eq("post_rst_rvalid", {o_a_rvalid, o_b_rvalid}, 0);
        tick();
        a_req = 1'b0; b_req = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
